// File: rtl/fir_stream_engine.sv
// fir_stream_engine: streaming direct-form signed FIR with a runtime tap count,
// an addressed coefficient write port, valid/ready on both sides, a programmable
// frame length and an automatic zero-fed drain (frame_len + ntaps - 1 results).
// Build option: define FIR_SAT_EN for a saturating output and a sticky o_sat flag.
// Without it the result wraps (low OW bits of the sum) and o_sat is tied low.
module fir_stream_engine #(
  parameter int NTAPS = 16,
  parameter int IW    = 12,
  parameter int TW    = 12,
  parameter int OW    = IW + TW + $clog2(NTAPS),
  parameter int LW    = 16,
  localparam int AW   = (NTAPS > 1) ? $clog2(NTAPS) : 1,
  localparam int CW   = $clog2(NTAPS + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [CW-1:0] i_ntaps,
  input  logic [LW-1:0] i_frame_len,
  input  logic          i_tap_wr,
  input  logic [AW-1:0] i_tap_addr,
  input  logic [TW-1:0] i_tap_data,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [IW-1:0] i_sample,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [OW-1:0] o_result,
  output logic          o_last,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_sat
);

  localparam int PW = IW + TW;
`ifdef FIR_SAT_EN
  localparam int ACW = OW + 2;
`else
  localparam int ACW = OW;
`endif
  // Sum width never drops below a single full-width product.
  localparam int XW = (ACW > PW) ? ACW : PW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_ntaps;
  logic [LW-1:0]         r_frame_len;
  logic [LW-1:0]         r_cnt;
  logic [CW-1:0]         r_dcnt;
  logic signed [TW-1:0]  r_tap [NTAPS];
  logic signed [IW-1:0]  r_dl  [NTAPS];
  logic                  r_valid;
  logic [OW-1:0]         r_result;
  logic                  r_last;
  logic                  r_done;

  logic                  w_slot_free;
  logic                  w_shift;
  logic signed [IW-1:0]  w_fed;
  logic signed [IW-1:0]  w_dl_next [NTAPS];
  logic signed [PW-1:0]  w_prod    [NTAPS];
  logic signed [XW-1:0]  w_acc;
  logic [OW-1:0]         w_res;
  logic [CW-1:0]         w_ntaps_lat;
  logic                  w_start_go;
  logic                  w_tap_we;
  logic                  w_last_sample;
  logic                  w_last_drain;
  logic                  w_is_last;

  assign w_slot_free   = !r_valid || i_ready;
  assign w_start_go    = (r_state == S_IDLE) && i_start && (i_frame_len != {LW{1'b0}});
  assign w_tap_we      = (r_state == S_IDLE) && i_tap_wr && (int'(i_tap_addr) < NTAPS);
  assign w_last_sample = (r_cnt == (r_frame_len - LW'(1)));
  assign w_last_drain  = (r_dcnt == (r_ntaps - CW'(2)));

  assign o_ready  = (r_state == S_RUN) && w_slot_free;
  assign o_valid  = r_valid;
  assign o_result = r_result;
  assign o_last   = r_last;
  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = r_done;

  // Pick what enters the delay line this cycle: live samples in RUN, zeros in DRAIN.
  always_comb begin
    w_shift   = 1'b0;
    w_fed     = {IW{1'b0}};
    w_is_last = 1'b0;
    case (r_state)
      S_RUN: begin
        w_shift   = i_valid && w_slot_free;
        w_fed     = i_sample;
        w_is_last = w_last_sample && (r_ntaps == CW'(1));
      end
      S_DRAIN: begin
        w_shift   = w_slot_free;
        w_fed     = {IW{1'b0}};
        w_is_last = w_last_drain;
      end
      default: begin
        w_shift   = 1'b0;
        w_fed     = {IW{1'b0}};
        w_is_last = 1'b0;
      end
    endcase
  end

  // Next delay-line contents and the masked convolution sum over active taps.
  always_comb begin
    w_acc        = {XW{1'b0}};
    w_dl_next[0] = w_fed;
    for (int k = 1; k < NTAPS; k++) begin
      w_dl_next[k] = r_dl[k-1];
    end
    for (int k = 0; k < NTAPS; k++) begin
      w_prod[k] = PW'(r_tap[k]) * PW'(w_dl_next[k]);
      if (CW'(k) < r_ntaps) begin
        w_acc = w_acc + XW'(w_prod[k]);
      end else begin
        w_acc = w_acc;
      end
    end
  end

  // Clamp the requested tap count into 1..NTAPS.
  always_comb begin
    if (i_ntaps == {CW{1'b0}}) begin
      w_ntaps_lat = CW'(1);
    end else if (i_ntaps > CW'(NTAPS)) begin
      w_ntaps_lat = CW'(NTAPS);
    end else begin
      w_ntaps_lat = i_ntaps;
    end
  end

`ifdef FIR_SAT_EN
  localparam logic signed [XW-1:0] SMAX = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  logic w_clip;
  logic r_sat;
  assign o_sat = r_sat;

  // Saturate the wide sum into the signed OW range and flag clipping.
  always_comb begin
    if (w_acc > SMAX) begin
      w_res  = SMAX[OW-1:0];
      w_clip = 1'b1;
    end else if (w_acc < SMIN) begin
      w_res  = SMIN[OW-1:0];
      w_clip = 1'b1;
    end else begin
      w_res  = w_acc[OW-1:0];
      w_clip = 1'b0;
    end
  end

  // Sticky clip flag, cleared when a new frame starts.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sat <= 1'b0;
    end else if (w_start_go) begin
      r_sat <= 1'b0;
    end else if (w_shift && w_clip) begin
      r_sat <= 1'b1;
    end
  end
`else
  assign w_res = w_acc[OW-1:0];
  assign o_sat = 1'b0;
`endif

  // Coefficient bank: writable only while idle, cleared by reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        r_tap[k] <= {TW{1'b0}};
      end
    end else if (w_tap_we) begin
      r_tap[i_tap_addr] <= i_tap_data;
    end
  end

  // Delay line: cleared at frame start, shifted on every accepted or drain sample.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        r_dl[k] <= {IW{1'b0}};
      end
    end else if (w_start_go) begin
      for (int k = 0; k < NTAPS; k++) begin
        r_dl[k] <= {IW{1'b0}};
      end
    end else if (w_shift) begin
      for (int k = 0; k < NTAPS; k++) begin
        r_dl[k] <= w_dl_next[k];
      end
    end
  end

  // Single-entry output slot; a new result may replace one being accepted.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid  <= 1'b0;
      r_result <= {OW{1'b0}};
      r_last   <= 1'b0;
    end else if (w_shift) begin
      r_valid  <= 1'b1;
      r_result <= w_res;
      r_last   <= w_is_last;
    end else if (i_ready) begin
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end
  end

  // Frame sequencer: IDLE -> RUN -> DRAIN -> FLUSH -> IDLE with done pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_ntaps     <= {CW{1'b0}};
      r_frame_len <= {LW{1'b0}};
      r_cnt       <= {LW{1'b0}};
      r_dcnt      <= {CW{1'b0}};
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_go) begin
            r_state     <= S_RUN;
            r_ntaps     <= w_ntaps_lat;
            r_frame_len <= i_frame_len;
            r_cnt       <= {LW{1'b0}};
            r_dcnt      <= {CW{1'b0}};
          end else if (i_start) begin
            r_done <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_shift) begin
            r_cnt <= r_cnt + LW'(1);
            if (w_last_sample) begin
              r_state <= (r_ntaps == CW'(1)) ? S_FLUSH : S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_shift) begin
            r_dcnt <= r_dcnt + CW'(1);
            if (w_last_drain) begin
              r_state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (r_valid && i_ready) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream_engine.sv
// Bench for fir_stream_engine: main 16-tap instance checked against a direct
// convolution scoreboard, plus two narrow instances for the saturation cases.
module tb_fir_stream_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  ntaps;
  logic [15:0] frame_len;
  logic        tap_wr;
  logic [3:0]  tap_addr;
  logic [11:0] tap_data;
  logic        in_valid;
  logic        out_ready_dut;
  logic [11:0] sample;
  logic        out_valid;
  logic        ready;
  logic [27:0] result;
  logic        last;
  logic        busy;
  logic        done;
  logic        sat;

  logic        s_start;
  logic [1:0]  s_ntaps;
  logic [15:0] s_frame_len;
  logic        s_tap_wr;
  logic [0:0]  s_tap_addr;
  logic [3:0]  s_tap_data;
  logic        s_valid;
  logic [3:0]  s_sample;
  logic        s9_ready, s9_valid, s9_last, s9_busy, s9_done, s9_sat;
  logic        s7_ready, s7_valid, s7_last, s7_busy, s7_done, s7_sat;
  logic [8:0]  s9_result;
  logic [6:0]  s7_result;

  typedef struct {
    logic [27:0] res;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   in_q[$];
  int   sq9[$];
  int   sq7[$];
  int   m_taps[16];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0;
  int   last_acc_cyc = -1;
  bit   mon_en = 1'b0;
  bit   rdy_toggle = 1'b0;
  bit   hold_chk = 1'b0;
  logic [27:0] hold_res;
  exp_t mon_e;
  int   mv;
  logic [8:0] ev9;
  logic [6:0] ev7;

  fir_stream_engine u_dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_ntaps(ntaps),
    .i_frame_len(frame_len), .i_tap_wr(tap_wr), .i_tap_addr(tap_addr),
    .i_tap_data(tap_data), .i_valid(in_valid), .o_ready(out_ready_dut),
    .i_sample(sample), .o_valid(out_valid), .i_ready(ready), .o_result(result),
    .o_last(last), .o_busy(busy), .o_done(done), .o_sat(sat)
  );

  fir_stream_engine #(.NTAPS(2), .IW(4), .TW(4), .OW(9), .LW(16)) u_s9 (
    .i_clk(clk), .i_reset(rst), .i_start(s_start), .i_ntaps(s_ntaps),
    .i_frame_len(s_frame_len), .i_tap_wr(s_tap_wr), .i_tap_addr(s_tap_addr),
    .i_tap_data(s_tap_data), .i_valid(s_valid), .o_ready(s9_ready),
    .i_sample(s_sample), .o_valid(s9_valid), .i_ready(1'b1), .o_result(s9_result),
    .o_last(s9_last), .o_busy(s9_busy), .o_done(s9_done), .o_sat(s9_sat)
  );

  fir_stream_engine #(.NTAPS(2), .IW(4), .TW(4), .OW(7), .LW(16)) u_s7 (
    .i_clk(clk), .i_reset(rst), .i_start(s_start), .i_ntaps(s_ntaps),
    .i_frame_len(s_frame_len), .i_tap_wr(s_tap_wr), .i_tap_addr(s_tap_addr),
    .i_tap_data(s_tap_data), .i_valid(s_valid), .o_ready(s7_ready),
    .i_sample(s_sample), .o_valid(s7_valid), .i_ready(1'b1), .o_result(s7_result),
    .o_last(s7_last), .o_busy(s7_busy), .o_done(s7_done), .o_sat(s7_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Downstream ready: steady high, or alternating when back-pressure is on.
  always @(posedge clk) begin
    #1;
    ready = rdy_toggle ? !ready : 1'b1;
  end

  // Main scoreboard: compare each accepted result, and hold stability on stalls.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_chk) begin
        n_tests++;
        if (out_valid !== 1'b1 || result !== hold_res) begin
          n_fail++;
          $display("FAIL hold_stable: o_valid=%0b o_result=%0d, required o_valid=1 o_result=%0d",
                   out_valid, $signed(result), $signed(hold_res));
        end
      end
      hold_chk = out_valid && !ready;
      hold_res = result;
      if (out_valid && ready) begin
        last_acc_cyc = cyc + 1;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got %0d with nothing expected", $signed(result));
        end else begin
          mon_e = exp_q.pop_front();
          if (result !== mon_e.res || last !== mon_e.last) begin
            n_fail++;
            $display("FAIL result: got %0d last=%0b, expected %0d last=%0b",
                     $signed(result), last, $signed(mon_e.res), mon_e.last);
          end
        end
      end
    end else begin
      hold_chk = 1'b0;
    end
  end

  // Saturation scoreboards for the two narrow instances (always ready).
  always @(negedge clk) begin
    if (s9_valid === 1'b1) begin
      n_tests++;
      if (sq9.size() == 0) begin
        n_fail++;
        $display("FAIL sat9_unexpected: got %0d", $signed(s9_result));
      end else begin
        mv = sq9.pop_front();
        ev9 = mv[8:0];
        if (s9_result !== ev9) begin
          n_fail++;
          $display("FAIL sat9_result: got %0d, expected %0d", $signed(s9_result), $signed(ev9));
        end
      end
    end
    if (s7_valid === 1'b1) begin
      n_tests++;
      if (sq7.size() == 0) begin
        n_fail++;
        $display("FAIL sat7_unexpected: got %0d", $signed(s7_result));
      end else begin
        mv = sq7.pop_front();
        ev7 = mv[6:0];
        if (s7_result !== ev7) begin
          n_fail++;
          $display("FAIL sat7_result: got %0d, expected %0d", $signed(s7_result), $signed(ev7));
        end
      end
    end
  end

  task automatic write_tap(input int addr, input int data, input bit idle);
    @(posedge clk); #1;
    tap_wr = 1'b1; tap_addr = addr[3:0]; tap_data = data[11:0];
    @(posedge clk); #1;
    tap_wr = 1'b0;
    if (idle) m_taps[addr] = data;
  endtask

  task automatic push_expected(input int nt_raw, input int fl);
    int nt;
    longint acc;
    exp_t e;
    nt = (nt_raw == 0) ? 1 : ((nt_raw > 16) ? 16 : nt_raw);
    for (int n = 0; n < fl + nt - 1; n++) begin
      acc = 0;
      for (int k = 0; k < nt; k++) begin
        if (n - k >= 0 && n - k < fl) acc += longint'(m_taps[k]) * longint'(in_q[n-k]);
      end
      e.res  = acc[27:0];
      e.last = (n == fl + nt - 2);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_frame(input int nt, input int fl);
    @(posedge clk); #1;
    ntaps = nt[4:0]; frame_len = fl[15:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed_samples(input int count);
    int  guard = 0;
    int  v;
    bit  acc;
    while (count > 0 && guard < 500) begin
      v = in_q[0];
      in_valid = 1'b1; sample = v[11:0];
      @(negedge clk); acc = out_ready_dut;
      @(posedge clk); #1;
      if (acc) begin
        void'(in_q.pop_front());
        count--;
      end
      guard++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (guard >= 500) begin
      n_fail++;
      $display("FAIL feed_timeout: %0d samples left, required 0", count);
    end
  endtask

  task automatic wait_done(input string name, output int dc);
    int g = 0;
    bit seen = 1'b0;
    dc = -1;
    while (!seen && g < 400) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; dc = cyc; end
      g++;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_done: o_done never pulsed, required a pulse", name);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_count: %0d results missing, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({out_valid, out_ready_dut, last, busy, done, sat} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_flags: {valid,ready,last,busy,done,sat}=%b, required 000000",
               {out_valid, out_ready_dut, last, busy, done, sat});
    end
    n_tests++;
    if (result !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_result: got %0d, required 0", result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_impulse(input bit bp);
    int dc;
    rdy_toggle = bp;
    if (!bp) begin
      write_tap(0, 1, 1'b1); write_tap(1, 2, 1'b1); write_tap(2, 3, 1'b1);
    end
    in_q = '{1, 0, 0, 0};
    push_expected(3, 4);
    start_frame(3, 4);
    feed_samples(4);
    wait_done(bp ? "backpressure" : "impulse", dc);
    n_tests++;
    if (dc !== last_acc_cyc) begin
      n_fail++;
      $display("FAIL done_timing: o_done at cycle %0d, required %0d", dc, last_acc_cyc);
    end
    rdy_toggle = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_tap_guard();
    int dc;
    in_q = '{2, 2};
    push_expected(3, 2);
    start_frame(3, 2);
    write_tap(0, 5, 1'b0);
    feed_samples(2);
    wait_done("tap_guard", dc);
    write_tap(0, 5, 1'b1);
    in_q = '{1};
    push_expected(3, 1);
    start_frame(3, 1);
    feed_samples(1);
    wait_done("tap_update", dc);
  endtask

  task automatic test_tap_limits();
    int dc;
    write_tap(0, 1, 1'b1);
    in_q = '{4, 5, 6};
    push_expected(0, 3);
    start_frame(0, 3);
    feed_samples(3);
    wait_done("ntaps_zero", dc);
    in_q = '{7, -3};
    push_expected(31, 2);
    start_frame(31, 2);
    feed_samples(2);
    wait_done("ntaps_clamp", dc);
    start_frame(1, 0);
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_frame: done=%0b valid=%0b busy=%0b, required 1 0 0", done, out_valid, busy);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_frame_pulse: done=%0b, required 0", done);
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    in_q = '{1, 2, 3, 4};
    push_expected(3, 4);
    start_frame(3, 4);
    feed_samples(2);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%0b busy=%0b, required 0 0", out_valid, busy);
    end
    exp_q.delete();
    in_q.delete();
    for (int k = 0; k < 16; k++) m_taps[k] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    in_q = '{1};
    push_expected(3, 1);
    start_frame(3, 1);
    feed_samples(1);
    wait_done("after_reset", dc);
  endtask

  task automatic test_saturation();
    int g = 0;
    int fed = 0;
    bit seen = 1'b0;
    bit acc;
    logic exp_sat7;
    sq9 = '{64, 128, 64};
`ifdef FIR_SAT_EN
    sq7 = '{63, 63, 63};
    exp_sat7 = 1'b1;
`else
    sq7 = '{-64, 0, -64};
    exp_sat7 = 1'b0;
`endif
    @(posedge clk); #1;
    s_tap_wr = 1'b1; s_tap_addr = 1'b0; s_tap_data = 4'b1000;
    @(posedge clk); #1;
    s_tap_addr = 1'b1;
    @(posedge clk); #1;
    s_tap_wr = 1'b0;
    s_ntaps = 2'd2; s_frame_len = 16'd2; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    s_valid = 1'b1; s_sample = 4'b1000;
    while (fed < 2 && g < 50) begin
      @(negedge clk); acc = s9_ready;
      @(posedge clk); #1;
      if (acc) fed++;
      g++;
    end
    s_valid = 1'b0;
    g = 0;
    while (!seen && g < 50) begin
      @(negedge clk);
      if (s9_done === 1'b1 && s7_done === 1'b1) seen = 1'b1;
      g++;
    end
    n_tests++;
    if (!seen || sq9.size() != 0 || sq7.size() != 0) begin
      n_fail++;
      $display("FAIL sat_frame: done=%0b left9=%0d left7=%0d, required 1 0 0", seen, sq9.size(), sq7.size());
    end
    n_tests++;
    if (s9_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL sat9_flag: o_sat=%0b, required 0", s9_sat);
    end
    n_tests++;
    if (s7_sat !== exp_sat7) begin
      n_fail++;
      $display("FAIL sat7_flag: o_sat=%0b, required %0b", s7_sat, exp_sat7);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ntaps = 5'd0; frame_len = 16'd0;
    tap_wr = 1'b0; tap_addr = 4'd0; tap_data = 12'd0; in_valid = 1'b0;
    sample = 12'd0; ready = 1'b1;
    s_start = 1'b0; s_ntaps = 2'd0; s_frame_len = 16'd0; s_tap_wr = 1'b0;
    s_tap_addr = 1'b0; s_tap_data = 4'd0; s_valid = 1'b0; s_sample = 4'd0;
    for (int k = 0; k < 16; k++) m_taps[k] = 0;
    test_reset();
    test_impulse(1'b0);
    test_impulse(1'b1);
    test_tap_guard();
    test_tap_limits();
    test_reset_mid();
    test_saturation();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
